sr_deserializer_rx: RTL and testbench
=====================================

# sr_deserializer_rx

Receive-side counterpart of the double-buffered serial transmitter: takes the 1-bit serial stream produced by the `sr` shift-register path, re-assembles 4-bit nibbles into 256-bit words, and hands completed words to a BRAM write port through a two-bank ping-pong buffer. Sits between the serial link (or loopback) and the receive BRAM, so received words land at the same addresses the transmit side read them from. Detects framing slips and buffer overflow and reports them for ChipScope triggering.

## Interface
- `WORD_W`, 256: bits per word; a multiple of `NIB_W`.
- `NIB_W`, 4: nibble width; matches the serializer's parallel width.
- `DEPTH`, 24: number of BRAM word addresses; address wraps `DEPTH-1` -> 0.
- `ADDR_W`, 5: width of `out_addr`; must satisfy 2^`ADDR_W` >= `DEPTH`.

- `clk` in 1: the only clock; all logic on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `sr_in` in 1: serial data bit.
- `sr_valid` in 1: `sr_in` is a valid bit this cycle.
- `sr_sof` in 1: qualified by `sr_valid`; marks bit 0 of a word.
- `out_valid` out 1: a completed word is presented.
- `out_ready` in 1: sink accepts the word this cycle.
- `out_data` out `WORD_W`: completed word.
- `out_addr` out `ADDR_W`: BRAM address for `out_data`.
- `locked` out 1: the deserializer is in state LOCKED.
- `overflow` out 1: sticky; set when a word completes and no free bank remains.
- `sync_err_cnt` out 8: saturating count of framing errors.
- `word_cnt` out 16: count of committed words; wraps at 2^16.

## Operation
- Bit order: within a nibble, LSB first. Nibble k occupies `[NIB_W*k+NIB_W-1 : NIB_W*k]`, and nibble 0 is received first. Equivalently, the word is filled from bit 0 upward, one bit per accepted cycle.
- States:
  - HUNT (reset state): bits are ignored until `sr_valid & sr_sof`. That bit is stored as bit 0, bit counter = 1, and the state moves to LOCKED.
  - LOCKED: each `sr_valid` cycle stores `sr_in` at the bit counter position and increments the counter (8 bits for the default `WORD_W`).
- Word boundaries in LOCKED:
  - Back-to-back words need no `sr_sof`.
  - `sr_sof` at bit position 0 is accepted silently.
  - `sr_sof` at a non-zero bit position is a framing error. `sync_err_cnt` increments, saturating at 255. The partial word is discarded and the current bit is taken as bit 0 of a new word. The state stays LOCKED.
- Banks: two `WORD_W` registers with `full[1:0]`, a fill pointer `fill_sel`, and a read pointer `rd_sel`.
- Commit: on acceptance of bit `WORD_W-1`:
  - Set `full[fill_sel]`, toggle `fill_sel`, increment `word_cnt`, and reset the bit counter to 0.
  - If the other bank is still full after this cycle's drain, set `overflow` and return to HUNT. The committed word is kept, and subsequent bits are dropped until the next `sr_sof`.
- Drain:
  - `out_valid = full[rd_sel]`, `out_data = bank[rd_sel]`, `out_addr` = address counter.
  - On `out_valid & out_ready`: clear `full[rd_sel]`, toggle `rd_sel`, and advance the address (`DEPTH-1` -> 0).
- Simultaneous events:
  - A drain and a commit in the same cycle are both applied.
  - A drain of the bank that is next to be filled frees it, so no overflow occurs.
- `overflow` clears only on `rst`.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_addr`=0, `locked`=0, `overflow`=0, `sync_err_cnt`=0, `word_cnt`=0. Internally: state=HUNT, `fill_sel`=0, `rd_sel`=0, `full`=00, bit counter=0.
- Latency: `out_valid` rises in the cycle after the edge that accepts bit `WORD_W-1`. `out_data` is stable while `out_valid` is high.
- Throughput: one bit per cycle sustained, with no gap between words while `out_ready` returns within `WORD_W` cycles.
- `locked` rises the cycle after the `sr_sof` bit is accepted and falls the cycle after an overflow commit.
- `rst` asserted mid-word discards everything, including banked words, immediately (asynchronous).

## Test plan
- Reset: assert `rst` mid-stream -> all outputs 0 in the same cycle; after release, with `sr_sof` never asserted, 500 bits -> `locked`=0 and `out_valid`=0.
- Single word, `out_ready`=1: `sr_sof` then 256 bits with nibble k = k mod 16 -> `out_valid` for 1 cycle, exactly 1 cycle after the last bit. Expected `out_data` = 0xFEDCBA9876543210 repeated 4 times, `out_addr`=0, `word_cnt`=1.
- Address wrap: 25 back-to-back words, `out_ready`=1 -> `out_addr` sequence 0..23 then 0, `word_cnt`=25, `overflow`=0.
- Backpressure: `out_ready`=0 and 3 back-to-back words ->
  - Words 1 and 2 are banked and `out_valid`=1.
  - At the word 2 commit, `overflow`=1 and `locked`=0.
  - Word 3 bits are dropped.
  - Then raising `out_ready` drains words 1 and 2 at addresses 0 and 1.
- Simultaneous drain: `out_ready` pulses in the same cycle as a commit while the other bank is full -> no overflow, `word_cnt` increments.
- Framing slip: `sr_sof` at bit 100 of a word -> `sync_err_cnt`=1, no word is output for the partial. The next word completes 256 bits after the slip bit with correct data. 300 slips -> `sync_err_cnt`=255.

Source files
------------

// File: rtl/sr_deserializer_rx.sv
// Serial receiver: rebuilds WORD_W-bit words from an LSB-first nibble stream into a two-bank ping-pong buffer.
// Latency: out_valid rises the cycle after the edge that accepts the last bit of a word.
// Backpressure: the banks absorb one word of out_ready stall; a word completing with no free bank sets sticky overflow and drops to HUNT.
module sr_deserializer_rx #(
  parameter int WORD_W = 256,
  parameter int NIB_W  = 4,
  parameter int DEPTH  = 24,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sr_in,
  input  logic              sr_valid,
  input  logic              sr_sof,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              locked,
  output logic              overflow,
  output logic [7:0]        sync_err_cnt,
  output logic [15:0]       word_cnt
);

  localparam int CNT_W    = $clog2(WORD_W);
  localparam int LAST_NIB = WORD_W / NIB_W - 1;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   bit_cnt;
  logic [WORD_W-1:0]  asm_word;
  logic [WORD_W-1:0]  asm_next;
  logic [WORD_W-1:0]  bank0;
  logic [WORD_W-1:0]  bank1;
  logic [1:0]         full;
  logic [1:0]         full_drained;
  logic [1:0]         full_next;
  logic               fill_sel;
  logic               rd_sel;

  logic               take;
  logic               slip;
  logic [CNT_W-1:0]   bit_pos;
  logic               last_bit;
  logic               commit;
  logic               commit_ok;
  logic               ovf_hit;
  logic               drain;
  int                 pos_i;

  // A bit is consumed in LOCKED on every valid cycle, or in HUNT only when it carries sof.
  assign take = sr_valid && (state == LOCKED || sr_sof);

  // sof away from bit 0 while locked means the framing slipped.
  assign slip = sr_valid && sr_sof && (state == LOCKED) && (bit_cnt != '0);

  // A fresh word starts at bit 0 on acquisition and after a slip.
  assign bit_pos = ((state == HUNT) || slip) ? '0 : bit_cnt;

  // Word end is the top bit of the last nibble.
  always_comb begin
    pos_i    = int'(bit_pos);
    last_bit = ((pos_i / NIB_W) == LAST_NIB) && ((pos_i % NIB_W) == (NIB_W - 1));
  end

  assign commit = take && last_bit;
  assign drain  = full[rd_sel] && out_ready;

  // Insert the incoming bit into the word under assembly.
  always_comb begin
    asm_next          = asm_word;
    asm_next[bit_pos] = sr_in;
  end

  // Bank occupancy: apply this cycle's drain first, then decide whether the commit fits.
  always_comb begin
    full_drained = full;
    if (drain) begin
      full_drained[rd_sel] = 1'b0;
    end
    // Target bank still occupied only after an overflow re-lock with no drain; the word is then lost.
    commit_ok = commit && !full_drained[fill_sel];
    ovf_hit   = commit && (full_drained[~fill_sel] || full_drained[fill_sel]);
    full_next = full_drained;
    if (commit_ok) begin
      full_next[fill_sel] = 1'b1;
    end
  end

  // Framing FSM: acquisition, bit assembly, slip counting and the overflow latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= HUNT;
      bit_cnt      <= '0;
      asm_word     <= '0;
      sync_err_cnt <= '0;
      overflow     <= 1'b0;
    end else if (take) begin
      asm_word <= asm_next;
      if (slip && (sync_err_cnt != 8'hFF)) begin
        sync_err_cnt <= sync_err_cnt + 8'd1;
      end
      if (commit) begin
        bit_cnt <= '0;
        if (ovf_hit) begin
          state    <= HUNT;
          overflow <= 1'b1;
        end else begin
          state <= LOCKED;
        end
      end else begin
        bit_cnt <= bit_pos + CNT_W'(1);
        state   <= LOCKED;
      end
    end
  end

  // Ping-pong banks: completed words land in the fill bank, which then flips.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank0    <= '0;
      bank1    <= '0;
      full     <= '0;
      fill_sel <= 1'b0;
      word_cnt <= '0;
    end else begin
      full <= full_next;
      if (commit_ok) begin
        if (fill_sel) begin
          bank1 <= asm_next;
        end else begin
          bank0 <= asm_next;
        end
        fill_sel <= ~fill_sel;
        word_cnt <= word_cnt + 16'd1;
      end
    end
  end

  // Drain side: flip the read bank and step the BRAM address on each handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_sel   <= 1'b0;
      out_addr <= '0;
    end else if (drain) begin
      rd_sel   <= ~rd_sel;
      out_addr <= (out_addr == ADDR_W'(DEPTH - 1)) ? '0 : out_addr + ADDR_W'(1);
    end
  end

  assign out_valid = full[rd_sel];
  assign out_data  = rd_sel ? bank1 : bank0;
  assign locked    = (state == LOCKED);

endmodule

// File: tb/tb_sr_deserializer_rx.sv
// Bench for sr_deserializer_rx: random serial stimulus against a queue-based model of framing and banking.
// Latency: outputs sampled on the falling edge, inputs driven 1 time unit after the rising edge.
// Backpressure: out_ready driven per cycle; drains observed at the falling edge before the accepting edge.
module tb_sr_deserializer_rx;

  localparam int WW = 256;
  localparam int AW = 5;
  localparam int DP = 24;

  logic          clk;
  logic          rst;
  logic          sr_in;
  logic          sr_valid;
  logic          sr_sof;
  logic          out_valid;
  logic          out_ready;
  logic [WW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic          locked;
  logic          overflow;
  logic [7:0]    sync_err_cnt;
  logic [15:0]   word_cnt;

  int total;
  int bad;

  // model state
  bit             m_part[$];
  logic [WW-1:0]  m_bankq[$];
  bit             m_locked;
  bit             m_ovf;
  int             m_err;
  int             m_wcnt;
  int             m_addr;
  logic [WW+AW-1:0] exp_q[$];
  logic [WW+AW-1:0] obs_q[$];

  sr_deserializer_rx #(.WORD_W(WW), .NIB_W(4), .DEPTH(DP), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .sr_in(sr_in), .sr_valid(sr_valid), .sr_sof(sr_sof),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
    .locked(locked), .overflow(overflow), .sync_err_cnt(sync_err_cnt), .word_cnt(word_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void model_reset();
    m_part.delete();
    m_bankq.delete();
    m_locked = 0;
    m_ovf = 0;
    m_err = 0;
    m_wcnt = 0;
    m_addr = 0;
    exp_q.delete();
    obs_q.delete();
  endfunction

  // Behavioural model: words as bit lists, banks as a FIFO of at most two words.
  function automatic void model_step(logic v, logic s, logic b, logic r);
    logic [WW-1:0] w;
    if (r && m_bankq.size() > 0) begin
      exp_q.push_back({m_bankq[0], AW'(m_addr)});
      m_bankq.delete(0);
      m_addr = (m_addr + 1) % DP;
    end
    if (!v) return;
    if (!m_locked) begin
      if (s) begin
        m_locked = 1;
        m_part.delete();
        m_part.push_back(b);
      end
    end else begin
      if (s && m_part.size() != 0) begin
        if (m_err < 255) m_err++;
        m_part.delete();
      end
      m_part.push_back(b);
    end
    if (m_locked && m_part.size() == WW) begin
      for (int i = 0; i < WW; i++) w[i] = m_part[i];
      m_part.delete();
      if (m_bankq.size() == 2) begin
        m_ovf = 1;
        m_locked = 0;
      end else begin
        m_bankq.push_back(w);
        m_wcnt = (m_wcnt + 1) % 65536;
        if (m_bankq.size() == 2) begin
          m_ovf = 1;
          m_locked = 0;
        end
      end
    end
  endfunction

  // One clock: called at posedge+1, returns at the next posedge+1.
  task automatic cyc(input logic v, input logic s, input logic b, input logic r);
    sr_valid = v; sr_sof = s; sr_in = b; out_ready = r;
    @(negedge clk);
    if (out_valid && out_ready) obs_q.push_back({out_data, out_addr});
    model_step(v, s, b, r);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    sr_valid = 0; sr_sof = 0; sr_in = 0; out_ready = 0;
    rst = 1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  function automatic logic [WW-1:0] rand_word();
    logic [WW-1:0] w;
    for (int i = 0; i < WW / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic send_word(input logic [WW-1:0] w, input logic first_sof, input logic r);
    for (int i = 0; i < WW; i++) cyc(1'b1, (i == 0) ? first_sof : 1'b0, w[i], r);
  endtask

  task automatic test_reset();
    logic [WW-1:0] w;
    sr_valid = 0; sr_sof = 0; sr_in = 0; out_ready = 0;
    rst = 1;
    #1;
    total++;
    if (out_valid !== 0 || out_data !== '0 || out_addr !== '0 || locked !== 0 || overflow !== 0 || sync_err_cnt !== 0 || word_cnt !== 0) begin
      bad++;
      $display("FAIL reset_initial: vld=%b addr=%0d lock=%b ovf=%b err=%0d wcnt=%0d, all required 0", out_valid, out_addr, locked, overflow, sync_err_cnt, word_cnt);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst = 0;
    // bank one word, start another, slip once, then reset mid-word
    w = rand_word();
    send_word(w, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'($urandom), 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'($urandom), 1'b0);
    total++;
    if (out_valid !== 1 || word_cnt !== 16'd1 || sync_err_cnt !== 8'd1 || locked !== 1) begin
      bad++;
      $display("FAIL reset_prestate: vld=%b wcnt=%0d err=%0d lock=%b, required 1 1 1 1", out_valid, word_cnt, sync_err_cnt, locked);
    end
    #2;
    rst = 1;
    #1;
    total++;
    if (out_valid !== 0 || out_data !== '0 || out_addr !== '0 || locked !== 0 || overflow !== 0 || sync_err_cnt !== 0 || word_cnt !== 0) begin
      bad++;
      $display("FAIL reset_async: vld=%b addr=%0d lock=%b ovf=%b err=%0d wcnt=%0d, all required 0", out_valid, out_addr, locked, overflow, sync_err_cnt, word_cnt);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst = 0;
    for (int i = 0; i < 500; i++) cyc(1'b1, 1'b0, 1'($urandom), 1'($urandom));
    total++;
    if (locked !== 0 || out_valid !== 0 || obs_q.size() != 0 || word_cnt !== 0) begin
      bad++;
      $display("FAIL reset_nosof: lock=%b vld=%b outputs=%0d wcnt=%0d, required 0 0 0 0", locked, out_valid, obs_q.size(), word_cnt);
    end
  endtask

  task automatic test_single_word();
    logic [63:0]   pat;
    logic [WW-1:0] expw;
    logic [3:0]    nib;
    do_reset();
    pat  = 64'hFEDCBA9876543210;
    expw = {4{pat}};
    for (int i = 0; i < WW; i++) begin
      nib = 4'((i / 4) % 16);
      cyc(1'b1, (i == 0) ? 1'b1 : 1'b0, nib[i % 4], 1'b1);
      if (i == WW - 2) begin
        total++;
        if (out_valid !== 0) begin
          bad++;
          $display("FAIL single_early: out_valid=%b before last bit, required 0", out_valid);
        end
      end
    end
    total++;
    if (out_valid !== 1 || out_data !== expw || out_addr !== '0 || word_cnt !== 16'd1) begin
      bad++;
      $display("FAIL single_word: vld=%b addr=%0d wcnt=%0d data=%h, required 1 0 1 %h", out_valid, out_addr, word_cnt, out_data, expw);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    total++;
    if (out_valid !== 0 || out_addr !== AW'(1)) begin
      bad++;
      $display("FAIL single_pulse: vld=%b addr=%0d after drain, required 0 1", out_valid, out_addr);
    end
  endtask

  task automatic test_addr_wrap();
    logic [WW-1:0] w[25];
    do_reset();
    for (int k = 0; k < 25; k++) w[k] = rand_word();
    for (int k = 0; k < 25; k++) send_word(w[k], (k == 0) ? 1'b1 : 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    total++;
    if (obs_q.size() != 25 || word_cnt !== 16'd25 || overflow !== 0) begin
      bad++;
      $display("FAIL wrap_count: words=%0d wcnt=%0d ovf=%b, required 25 25 0", obs_q.size(), word_cnt, overflow);
    end
    for (int k = 0; k < 25 && k < obs_q.size(); k++) begin
      total++;
      if (obs_q[k] !== {w[k], AW'(k % DP)}) begin
        bad++;
        $display("FAIL wrap_word%0d: addr=%0d, required addr=%0d with matching data", k, obs_q[k][AW-1:0], k % DP);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [WW-1:0] w1, w2, w3;
    do_reset();
    w1 = rand_word(); w2 = rand_word(); w3 = rand_word();
    send_word(w1, 1'b1, 1'b0);
    total++;
    if (out_valid !== 1 || overflow !== 0 || locked !== 1) begin
      bad++;
      $display("FAIL bp_word1: vld=%b ovf=%b lock=%b, required 1 0 1", out_valid, overflow, locked);
    end
    send_word(w2, 1'b0, 1'b0);
    total++;
    if (overflow !== 1 || locked !== 0 || word_cnt !== 16'd2) begin
      bad++;
      $display("FAIL bp_word2: ovf=%b lock=%b wcnt=%0d, required 1 0 2", overflow, locked, word_cnt);
    end
    send_word(w3, 1'b0, 1'b0);
    total++;
    if (word_cnt !== 16'd2 || locked !== 0) begin
      bad++;
      $display("FAIL bp_word3_drop: wcnt=%0d lock=%b, required 2 0", word_cnt, locked);
    end
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    total++;
    if (obs_q.size() != 2 || out_valid !== 0 || overflow !== 1) begin
      bad++;
      $display("FAIL bp_drain: words=%0d vld=%b ovf=%b, required 2 0 1", obs_q.size(), out_valid, overflow);
    end else begin
      total++;
      if (obs_q[0] !== {w1, AW'(0)} || obs_q[1] !== {w2, AW'(1)}) begin
        bad++;
        $display("FAIL bp_order: addrs=%0d,%0d, required 0,1 with words 1,2", obs_q[0][AW-1:0], obs_q[1][AW-1:0]);
      end
    end
  endtask

  task automatic test_simul_drain();
    logic [WW-1:0] wa, wb;
    do_reset();
    wa = rand_word(); wb = rand_word();
    send_word(wa, 1'b1, 1'b0);
    for (int i = 0; i < WW; i++) cyc(1'b1, 1'b0, wb[i], (i == WW - 1) ? 1'b1 : 1'b0);
    total++;
    if (overflow !== 0 || word_cnt !== 16'd2 || locked !== 1 || out_valid !== 1 || out_addr !== AW'(1)) begin
      bad++;
      $display("FAIL simul_commit: ovf=%b wcnt=%0d lock=%b vld=%b addr=%0d, required 0 2 1 1 1", overflow, word_cnt, locked, out_valid, out_addr);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    total++;
    if (obs_q.size() != 2 || obs_q[0] !== {wa, AW'(0)} || obs_q[1] !== {wb, AW'(1)}) begin
      bad++;
      $display("FAIL simul_order: words=%0d, required 2 words A@0 B@1", obs_q.size());
    end
  endtask

  task automatic test_framing();
    logic [WW-1:0] wa, wb;
    do_reset();
    wa = rand_word(); wb = rand_word();
    for (int i = 0; i < 100; i++) cyc(1'b1, (i == 0) ? 1'b1 : 1'b0, wa[i], 1'b1);
    for (int i = 0; i < WW; i++) cyc(1'b1, (i == 0) ? 1'b1 : 1'b0, wb[i], 1'b1);
    total++;
    if (sync_err_cnt !== 8'd1 || out_valid !== 1 || out_data !== wb || obs_q.size() != 0) begin
      bad++;
      $display("FAIL slip_word: err=%0d vld=%b early_words=%0d data=%h, required 1 1 0 %h", sync_err_cnt, out_valid, obs_q.size(), out_data, wb);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    total++;
    if (obs_q.size() != 1 || word_cnt !== 16'd1) begin
      bad++;
      $display("FAIL slip_partial: words=%0d wcnt=%0d, required 1 1", obs_q.size(), word_cnt);
    end
    for (int i = 0; i <= 300; i++) begin
      cyc(1'b1, 1'b1, 1'($urandom), 1'b1);
      cyc(1'b1, 1'b0, 1'($urandom), 1'b1);
      if (i == 200) begin
        total++;
        if (sync_err_cnt !== 8'd201) begin
          bad++;
          $display("FAIL slip_mid: err=%0d, required 201", sync_err_cnt);
        end
      end
    end
    total++;
    if (sync_err_cnt !== 8'd255 || m_err != 255) begin
      bad++;
      $display("FAIL slip_saturate: err=%0d model=%0d, required 255", sync_err_cnt, m_err);
    end
    total++;
    if (obs_q.size() != exp_q.size() || (obs_q.size() > 0 && obs_q[0] !== exp_q[0])) begin
      bad++;
      $display("FAIL slip_model: words=%0d, required %0d", obs_q.size(), exp_q.size());
    end
  endtask

  task automatic test_random();
    logic v, s, r;
    int   nmis;
    do_reset();
    cyc(1'b1, 1'b1, 1'($urandom), 1'b0);
    for (int i = 0; i < 6000; i++) begin
      v = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 499) == 0);
      r = (i % 700 < 350) ? 1'($urandom) : ($urandom_range(0, 7) != 0);
      cyc(v, s, 1'($urandom), r);
    end
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL rand_count: words=%0d, required %0d", obs_q.size(), exp_q.size());
    end
    nmis = 0;
    for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) if (obs_q[k] !== exp_q[k]) nmis++;
    total++;
    if (nmis != 0) begin
      bad++;
      $display("FAIL rand_data: %0d words differ, required 0", nmis);
    end
    total++;
    if (locked !== 1'(m_locked) || overflow !== 1'(m_ovf) || sync_err_cnt !== 8'(m_err) || word_cnt !== 16'(m_wcnt) || out_addr !== AW'(m_addr)) begin
      bad++;
      $display("FAIL rand_state: lock=%b ovf=%b err=%0d wcnt=%0d addr=%0d, required %0d %0d %0d %0d %0d",
               locked, overflow, sync_err_cnt, word_cnt, out_addr, m_locked, m_ovf, m_err, m_wcnt, m_addr);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_single_word();
    test_addr_wrap();
    test_backpressure();
    test_simul_drain();
    test_framing();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
